seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Restoring sequential divider, signed or unsigned, one quotient bit per cycle.
// Latency: done pulses WIDTH+2 cycles after start is accepted; results held until the next done.
// Backpressure: start is only sampled in IDLE, so a start seen while busy is dropped.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   dmag_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] a_raw_r;
    logic             a_sgn_r, b_sgn_r, smode_r, zero_r, ovf_r;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] shifted, diff;
    logic             q_neg, r_neg;
    logic [WIDTH-1:0] q_fin, r_fin;

    // Magnitudes fit in WIDTH bits as unsigned values, including |most-negative|.
    assign a_neg = signed_mode & A[WIDTH-1];
    assign b_neg = signed_mode & B[WIDTH-1];
    assign a_mag = a_neg ? (~A + ONE_W) : A;
    assign b_mag = b_neg ? (~B + ONE_W) : B;

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dmag_r};

    assign q_neg = smode_r & (a_sgn_r ^ b_sgn_r);
    assign r_neg = smode_r & a_sgn_r;
    assign q_fin = q_neg ? (~quo_r + ONE_W) : quo_r;
    assign r_fin = r_neg ? (~rem_r[WIDTH-1:0] + ONE_W) : rem_r[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem_r       <= '0;
            dmag_r      <= '0;
            quo_r       <= '0;
            a_raw_r     <= '0;
            a_sgn_r     <= 1'b0;
            b_sgn_r     <= 1'b0;
            smode_r     <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= CNT_INIT;
                        rem_r   <= '0;
                        dmag_r  <= {1'b0, b_mag};
                        quo_r   <= a_mag;
                        a_raw_r <= A;
                        a_sgn_r <= A[WIDTH-1];
                        b_sgn_r <= B[WIDTH-1];
                        smode_r <= signed_mode;
                        zero_r  <= (B == '0);
                        ovf_r   <= signed_mode & (A == MOST_NEG) & (B == '1);
                    end
                end
                RUN: begin
                    // Dividend bits leave the top of quo_r as quotient bits enter the bottom.
                    rem_r <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
                    quo_r <= {quo_r[WIDTH-2:0], ~diff[WIDTH+1]};
                    cnt   <= cnt - CNT_LAST;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_r;
                    overflow    <= ovf_r & ~zero_r;
                    if (zero_r) begin
                        Quotient  <= '1;
                        Remainder <= a_raw_r;
                    end else begin
                        Quotient  <= q_fin;
                        Remainder <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider (WIDTH=8) with directed corner cases.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       signed_mode;
    logic [7:0] A, B;
    logic       busy, done;
    logic [7:0] Quotient, Remainder;
    logic       div_by_zero, overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   last_out;

    seq_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero in signed mode.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input int due);
        exp_t e;
        int   na, nb, q, r;
        e.due = due;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (b == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            if (s) begin
                na = $signed(a);
                nb = $signed(b);
            end else begin
                na = int'(a);
                nb = int'(b);
            end
            if (s && na == -128 && nb == -1) begin
                e.q  = a;
                e.r  = 8'd0;
                e.ov = 1'b1;
            end else begin
                q   = na / nb;
                r   = na % nb;
                e.q = q[7:0];
                e.r = r[7:0];
            end
        end
        return e;
    endfunction

    // Monitor: pops an expectation on every done, otherwise checks outputs hold.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_out = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_latency", cyc, e.due);
                chk("quotient", int'(Quotient), int'(e.q));
                chk("remainder", int'(Remainder), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                chk("overflow", int'(overflow), int'(e.ov));
            end
            last_out = int'({Quotient, Remainder, div_by_zero, overflow});
        end else begin
            chk("outputs_hold", int'({Quotient, Remainder, div_by_zero, overflow}), last_out);
        end
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle at cycle %0d", cyc);
        end
        A           = a;
        B           = b;
        signed_mode = s;
        start       = 1'b1;
        sb.push_back(model(a, b, s, cyc + 10));
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quotient", int'(Quotient), 0);
        chk("reset_remainder", int'(Remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        chk("reset_ovf", int'(overflow), 0);
        #22 rst_n = 1'b1;

        issue(8'd100, 8'd7, 1'b0);
        issue(8'h9C, 8'd7, 1'b1);
        issue(8'd100, 8'hF9, 1'b1);
        issue(8'd55, 8'd0, 1'b0);
        issue(8'd55, 8'd0, 1'b1);
        issue(8'h80, 8'hFF, 1'b1);
        issue(8'h80, 8'hFF, 1'b0);

        // Start with new operands during RUN must not disturb the operation.
        issue(8'd100, 8'd7, 1'b0);
        @(negedge clk);
        chk("busy_in_run", int'(busy), 1);
        A           = 8'd3;
        B           = 8'd1;
        signed_mode = 1'b1;
        start       = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        issue(8'd200, 8'd9, 1'b0);

        // Asynchronous reset in RUN cycle 4 aborts with no done.
        issue(8'd100, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_outputs", int'({Quotient, Remainder, div_by_zero, overflow}), 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        issue(8'd100, 8'd7, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
            issue(ra, rb, 1'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
